mpu_table_writer: RTL and testbench
===================================

# mpu_table_writer

Writer end of the MPU region table held in main memory. It accepts region descriptors from a host-side configuration port and writes them as word bursts into the table at `MPU_START_ADDR`, where `mem_mpu` later fetches them into its cache. It arbitrates for the memory port with a request/grant pair, writes each entry's header word last so a half-written entry is never marked valid, and pulses `table_updated` so the MPU marks its cache stale.

## Interface
Parameters:
- `MPU_START_ADDR`, 768: word address of table word 0.
- `MPU_ITEM_NUM`, 16: number of entries.
- `MPU_ITEM_LEN`, 5: words per entry, must be ≥ 5.
- `IDX_W`, 4: width of `cfg_index`.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `cfg_valid` in 1: host command valid.
- `cfg_ready` out 1: block idle, command can be accepted.
- `cfg_op` in 1: 0 = write entry, 1 = clear whole table.
- `cfg_index` in IDX_W: entry number.
- `cfg_enable` in 1: entry valid bit.
- `cfg_pc_lo`, `cfg_pc_hi` in 32: instruction word-address bounds, inclusive.
- `cfg_d_lo`, `cfg_d_hi` in 32: data address bounds, inclusive.
- `cfg_done` out 1: 1-cycle pulse, command completed.
- `cfg_err` out 1: 1-cycle pulse, command rejected.
- `busy` out 1: not idle.
- `mem_req` out 1: requests the memory port.
- `mem_gnt` in 1: memory port granted this cycle.
- `mem_wen` out 4: byte write enables.
- `mem_addr` out 22: word address.
- `mem_wdata` out 32: write data.
- `table_updated` out 1: 1-cycle pulse to `mem_mpu` cache invalidate.

## Operation
- States: IDLE, BURST.
  - `cfg_ready` = (state == IDLE).
  - `busy` = (state == BURST).
- Accept on a rising edge with `cfg_valid && cfg_ready`. All `cfg_*` fields are latched that edge and are don't-care afterwards.
- Error check, evaluated on the accept edge. A command is rejected when:
  - `cfg_op` = 0 and `cfg_index` ≥ `MPU_ITEM_NUM`, or
  - `cfg_op` = 0, `cfg_enable` = 1, and (`cfg_pc_lo` > `cfg_pc_hi` or `cfg_d_lo` > `cfg_d_hi`). Compares are unsigned.
  - Disabled entries skip the bounds check.
- On rejection: `cfg_err` pulses next cycle, state stays IDLE, no memory activity.
- Entry write, base = `MPU_START_ADDR` + `index`·`MPU_ITEM_LEN` (22-bit, truncating). Word order:
  - +1 = `pc_lo`
  - +2 = `pc_hi`
  - +3 = `d_lo`
  - +4 = `d_hi`
  - +5 … +LEN−1 = 0
  - +0 = header, written last: bit0 = enable, bits[7:4] = index, other bits 0.
- Clear: writes 0 to words `MPU_START_ADDR` … `MPU_START_ADDR` + `MPU_ITEM_NUM`·`MPU_ITEM_LEN` inclusive, ascending. That is 81 words at defaults, covering the reader's full fetch range. Clear has no error check.
- Memory outputs, combinational from state, word counter, and `mem_gnt`:
  - `mem_req` = 1 in BURST.
  - `mem_wen` = 4'hF when BURST && `mem_gnt`, else 0.
  - `mem_addr` / `mem_wdata` show the current word in BURST, 0 in IDLE.
- A word is committed on each edge where `mem_wen` ≠ 0; the word counter then advances.
- `mem_gnt` low stalls: counter holds and `mem_req` stays high. Grant may toggle on any cycle.
- After the last word commits: state returns to IDLE, and `cfg_done` and `table_updated` pulse together the following cycle.

## Timing
- Reset values, all outputs:
  - `cfg_ready` = 1
  - `busy`, `mem_req`, `cfg_done`, `cfg_err`, `table_updated` = 0
  - `mem_wen`, `mem_addr`, `mem_wdata` = 0
- Entry write with grant held high:
  - accept edge E
  - BURST in cycles E+1 … E+LEN
  - `cfg_done` / `table_updated` high in cycle E+LEN+1, with `cfg_ready` = 1 in the same cycle.
- Latency = 1 + words + (grant-low cycles). Words per command: LEN for an entry write, `MPU_ITEM_NUM`·LEN+1 for a clear.
- Back-to-back commands: a new command may be accepted in the `cfg_done` cycle. Its pulses never overlap the previous command's pulses.
- `cfg_err` latency is 1 cycle; `cfg_ready` stays 1 throughout.
- Reset mid-burst:
  - Next cycle all outputs are at reset values and state is IDLE.
  - Committed words stay in memory; the header is unwritten if the reset came before the last word.
  - No `cfg_done` or `table_updated`.
- `cfg_valid` while busy is ignored, with no queueing. The host holds `cfg_valid` until it sees `cfg_ready`.

## Test plan
- Write entry 2 (pc 0x10..0x40, data 0x300..0x3FF, enable), `mem_gnt` = 1:
  - writes to 779, 780, 781, 782, then 778 = 0x21, on 5 consecutive cycles.
  - `cfg_done` and `table_updated` pulse in cycle 6.
- Same command with `mem_gnt` low on alternate cycles: same 5 writes in the same order, 10 BURST cycles, no duplicate or skipped address.
- Rejected commands, each giving a `cfg_err` pulse 1 cycle after accept, `mem_req` never high, no `table_updated`:
  - `cfg_index` = 16
  - enable with `pc_lo` = 0x50 > `pc_hi` = 0x40
- Clear: 81 writes of 0 to addresses 768 … 848, then `cfg_done`. A disabled-entry write with inverted bounds is accepted without error.
- Reset asserted after the 3rd word of an entry write: no header write to the entry's +0 word, outputs at reset values the next cycle. A following command completes normally.
- Back-to-back: a second entry write issued in the first command's `cfg_done` cycle is accepted immediately. There are exactly 2 `table_updated` pulses, 6 cycles apart.

Source files
------------

// File: rtl/mpu_table_writer.sv
// Writer for the MPU region table in main memory: turns host region commands
// into word bursts, header word last, and flags the MPU cache stale on completion.
module mpu_table_writer #(
  parameter int MPU_START_ADDR = 768,
  parameter int MPU_ITEM_NUM   = 16,
  parameter int MPU_ITEM_LEN   = 5,
  parameter int IDX_W          = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_op,
  input  logic [IDX_W-1:0] cfg_index,
  input  logic             cfg_enable,
  input  logic [31:0]      cfg_pc_lo,
  input  logic [31:0]      cfg_pc_hi,
  input  logic [31:0]      cfg_d_lo,
  input  logic [31:0]      cfg_d_hi,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             busy,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [3:0]       mem_wen,
  output logic [21:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             table_updated
);

  // state   | meaning
  // S_IDLE  | waiting for a host command, cfg_ready high
  // S_BURST | writing words of an entry or of the whole-table clear

  localparam int CLR_WORDS = MPU_ITEM_NUM * MPU_ITEM_LEN + 1;
  localparam int CNT_W     = $clog2(CLR_WORDS + 1);
  localparam logic [CNT_W-1:0] ENT_LAST = CNT_W'(MPU_ITEM_LEN - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WORDS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             op_q;
  logic             en_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      pc_lo_q, pc_hi_q, d_lo_q, d_hi_q;

  logic             accept;
  logic             cmd_bad;
  logic             last_word;
  logic [CNT_W-1:0] offset;
  logic [21:0]      base;
  logic [21:0]      addr_word;
  logic [31:0]      data_word;
  logic [31:0]      header;

  assign accept = cfg_valid && (state_q == S_IDLE);

  always_comb begin
    cmd_bad = 1'b0;
    if (!cfg_op) begin
      if (32'(cfg_index) >= 32'(MPU_ITEM_NUM))
        cmd_bad = 1'b1;
      // Disabled entries are never matched by the reader, so their bounds are free.
      if (cfg_enable && ((cfg_pc_lo > cfg_pc_hi) || (cfg_d_lo > cfg_d_hi)))
        cmd_bad = 1'b1;
    end
  end

  // Entry words go out as +1..+LEN-1 and then +0, so the header lands last.
  assign offset = (cnt_q == ENT_LAST) ? '0 : cnt_q + CNT_W'(1);
  assign base   = 22'(MPU_START_ADDR) + 22'(32'(idx_q) * 32'(MPU_ITEM_LEN));
  assign header = ((32'(idx_q) & 32'h0000_000F) << 4) | 32'(en_q);

  always_comb begin
    data_word = 32'h0;
    if (!op_q) begin
      case (offset)
        CNT_W'(0): data_word = header;
        CNT_W'(1): data_word = pc_lo_q;
        CNT_W'(2): data_word = pc_hi_q;
        CNT_W'(3): data_word = d_lo_q;
        CNT_W'(4): data_word = d_hi_q;
        default:   data_word = 32'h0;
      endcase
    end
  end

  assign addr_word = op_q ? 22'(MPU_START_ADDR) + 22'(cnt_q) : base + 22'(offset);
  assign last_word = op_q ? (cnt_q == CLR_LAST) : (cnt_q == ENT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= 1'b0;
      en_q    <= 1'b0;
      idx_q   <= '0;
      pc_lo_q <= 32'h0;
      pc_hi_q <= 32'h0;
      d_lo_q  <= 32'h0;
      d_hi_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        op_q    <= cfg_op;
        en_q    <= cfg_enable;
        idx_q   <= cfg_index;
        pc_lo_q <= cfg_pc_lo;
        pc_hi_q <= cfg_pc_hi;
        d_lo_q  <= cfg_d_lo;
        d_hi_q  <= cfg_d_hi;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_wen   = 4'h0;
    mem_addr  = 22'h0;
    mem_wdata = 32'h0;
    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (accept) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_BURST;
            cnt_d   = '0;
          end
        end
      end
      S_BURST: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = addr_word;
        mem_wdata = data_word;
        if (mem_gnt) begin
          mem_wen = 4'hF;
          if (last_word) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_done      = done_q;
  assign table_updated = done_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_mpu_table_writer.sv
// Self-checking bench for mpu_table_writer: directed plan cases plus random
// commands scored against a word-list model of the table layout.
module tb_mpu_table_writer;

  localparam int START = 768;
  localparam int N     = 16;
  localparam int LEN   = 5;
  localparam int IW    = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_op;
  logic [IW-1:0] cfg_index;
  logic          cfg_enable;
  logic [31:0]   cfg_pc_lo, cfg_pc_hi, cfg_d_lo, cfg_d_hi;
  logic          cfg_done, cfg_err, busy, mem_req, mem_gnt;
  logic [3:0]    mem_wen;
  logic [21:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          table_updated;

  mpu_table_writer #(
    .MPU_START_ADDR(START), .MPU_ITEM_NUM(N), .MPU_ITEM_LEN(LEN), .IDX_W(IW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
    .cfg_index(cfg_index), .cfg_enable(cfg_enable),
    .cfg_pc_lo(cfg_pc_lo), .cfg_pc_hi(cfg_pc_hi),
    .cfg_d_lo(cfg_d_lo), .cfg_d_hi(cfg_d_hi),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .busy(busy),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .table_updated(table_updated)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          tu_cyc[$];
  logic [31:0] mem_img[int];
  int          exp_a[$];
  logic [31:0] exp_d[$];
  bit          g;

  always @(posedge clk) cyc++;

  // Memory image built from what the DUT actually drives; inputs that can move
  // mem_* (mem_gnt) only change at posedge+1, so negedge values are stable.
  always @(negedge clk) begin
    if (mem_wen != 4'h0) mem_img[int'(mem_addr)] = mem_wdata;
    if (table_updated) tu_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the list of (address, data) writes a command must produce.
  task automatic build_exp(input bit op, input int idx, input bit en,
                           input logic [31:0] pl, ph, dl, dh);
    int b;
    exp_a.delete();
    exp_d.delete();
    if (op) begin
      for (int a = START; a <= START + N * LEN; a++) begin
        exp_a.push_back(a);
        exp_d.push_back(32'h0);
      end
    end else begin
      b = START + idx * LEN;
      exp_a.push_back(b + 1); exp_d.push_back(pl);
      exp_a.push_back(b + 2); exp_d.push_back(ph);
      exp_a.push_back(b + 3); exp_d.push_back(dl);
      exp_a.push_back(b + 4); exp_d.push_back(dh);
      for (int k = 5; k < LEN; k++) begin
        exp_a.push_back(b + k); exp_d.push_back(32'h0);
      end
      exp_a.push_back(b);
      exp_d.push_back(32'(idx * 16 + (en ? 1 : 0)));
    end
  endtask

  function automatic bit next_gnt(input int mode, input bit prev);
    if (mode == 0) return 1'b1;
    if (mode == 1) return !prev;
    return 1'(($urandom_range(0, 1)));
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, cfg_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_done"}, cfg_done, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_tu"}, table_updated, 0);
    chk({tag, "_wen"}, mem_wen, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_gnt = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_done", cfg_done, 0);
      chk("idle_tu", table_updated, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_wen", mem_wen, 0);
      chk("idle_ready", cfg_ready, 1);
    end
  endtask

  // Called and returning at a negedge. gmode: 0 grant high, 1 alternate, 2 random.
  task automatic run_cmd(input bit op, input int idx, input bit en,
                         input logic [31:0] pl, ph, dl, dh,
                         input int gmode, input int rst_after);
    bit bad, done_seen;
    int words, lows, nw, c, ea;
    logic [31:0] ed;
    bad = !op && ((idx >= N) || (en && ((pl > ph) || (dl > dh))));
    build_exp(op, idx, en, pl, ph, dl, dh);
    words = exp_a.size();
    chk("ready_at_issue", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_op = op; cfg_index = IW'(idx); cfg_enable = en;
    cfg_pc_lo = pl; cfg_pc_hi = ph; cfg_d_lo = dl; cfg_d_hi = dh;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_op = 1'($urandom_range(0, 1)); cfg_index = IW'($urandom);
    cfg_enable = 1'($urandom_range(0, 1));
    cfg_pc_lo = $urandom; cfg_pc_hi = $urandom; cfg_d_lo = $urandom; cfg_d_hi = $urandom;
    g = next_gnt(gmode, 1'b1);
    mem_gnt = g;
    @(negedge clk);
    if (bad) begin
      chk("err_pulse", cfg_err, 1);
      chk("err_ready", cfg_ready, 1);
      chk("err_req", mem_req, 0);
      chk("err_tu", table_updated, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_one_cycle", cfg_err, 0);
      chk("err_req2", mem_req, 0);
      chk("err_tu2", table_updated, 0);
      return;
    end
    chk("no_err", cfg_err, 0);
    lows = 0; nw = 0; done_seen = 1'b0;
    for (c = 1; c <= 600; c++) begin
      if (cfg_done) begin
        done_seen = 1'b1;
        break;
      end
      chk("busy", busy, 1);
      chk("req", mem_req, 1);
      chk("ready_busy", cfg_ready, 0);
      chk("tu_early", table_updated, 0);
      if (mem_gnt) begin
        chk("wen", mem_wen, 4'hF);
        if (exp_a.size() == 0) begin
          chk("extra_write_addr", mem_addr, 22'h3FFFFF);
        end else begin
          ea = exp_a.pop_front();
          ed = exp_d.pop_front();
          chk("wr_addr", mem_addr, 22'(ea));
          chk("wr_data", mem_wdata, ed);
        end
        nw++;
      end else begin
        chk("wen_stall", mem_wen, 0);
        lows++;
      end
      if (rst_after != 0 && nw == rst_after) begin
        @(posedge clk); #1;
        mem_gnt = 1'b0; resetn = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b1; mem_gnt = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        idle_cycles(3);
        return;
      end
      @(posedge clk); #1;
      g = next_gnt(gmode, g);
      mem_gnt = g;
      @(negedge clk);
    end
    chk("done_seen", done_seen, 1);
    if (done_seen) begin
      chk("tu_with_done", table_updated, 1);
      chk("ready_at_done", cfg_ready, 1);
      chk("busy_at_done", busy, 0);
      chk("words_left", exp_a.size(), 0);
      chk("latency", c, 1 + words + lows);
    end
  endtask

  initial begin
    int hdr_a;
    resetn = 1'b0; cfg_valid = 1'b0; cfg_op = 1'b0; cfg_index = '0; cfg_enable = 1'b0;
    cfg_pc_lo = '0; cfg_pc_hi = '0; cfg_d_lo = '0; cfg_d_hi = '0; mem_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_gnt = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);

    // Entry 2, grant held high.
    run_cmd(0, 2, 1, 32'h10, 32'h40, 32'h300, 32'h3FF, 0, 0);
    chk("e2_hdr", mem_img[778], 32'h21);
    chk("e2_pclo", mem_img[779], 32'h10);
    chk("e2_dhi", mem_img[782], 32'h3FF);
    idle_cycles(2);

    // Same command with grant alternating.
    run_cmd(0, 2, 1, 32'h10, 32'h40, 32'h300, 32'h3FF, 1, 0);
    idle_cycles(1);

    // Rejections.
    tu_cyc.delete();
    run_cmd(0, 16, 1, 32'h10, 32'h40, 32'h300, 32'h3FF, 0, 0);
    run_cmd(0, 3, 1, 32'h50, 32'h40, 32'h300, 32'h3FF, 0, 0);
    idle_cycles(2);
    chk("rej_no_tu", tu_cyc.size(), 0);

    // Clear, then a disabled entry with inverted bounds.
    run_cmd(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_first", mem_img[768], 0);
    chk("clr_last", mem_img[848], 0);
    idle_cycles(1);
    run_cmd(0, 7, 0, 32'h90, 32'h20, 32'h900, 32'h100, 2, 0);
    chk("dis_hdr", mem_img[768 + 35], 32'h70);
    idle_cycles(1);

    // Reset after the third word of entry 5.
    hdr_a = START + 5 * LEN;
    mem_img.delete(hdr_a);
    tu_cyc.delete();
    run_cmd(0, 5, 1, 32'h100, 32'h200, 32'h1000, 32'h2000, 0, 3);
    chk("rst_hdr_unwritten", mem_img.exists(hdr_a), 0);
    chk("rst_no_tu", tu_cyc.size(), 0);
    run_cmd(0, 5, 1, 32'h100, 32'h200, 32'h1000, 32'h2000, 0, 0);
    chk("after_rst_hdr", mem_img[hdr_a], 32'h51);
    idle_cycles(1);

    // Back-to-back: second command issued in the first's done cycle.
    tu_cyc.delete();
    run_cmd(0, 1, 1, 32'h0, 32'hFF, 32'h10, 32'h20, 0, 0);
    run_cmd(0, 9, 1, 32'h5, 32'h6, 32'h7, 32'h8, 0, 0);
    idle_cycles(2);
    chk("b2b_pulses", tu_cyc.size(), 2);
    if (tu_cyc.size() == 2) chk("b2b_spacing", tu_cyc[1] - tu_cyc[0], 6);

    // Random commands against the model.
    for (int i = 0; i < 30; i++) begin
      bit rop, ren;
      int ridx;
      logic [31:0] pl, ph, dl, dh;
      rop  = ($urandom_range(0, 9) == 0);
      ridx = $urandom_range(0, 17);
      ren  = 1'($urandom_range(0, 1));
      pl = $urandom_range(0, 32'h7FFF_FFFF);
      dl = $urandom_range(0, 32'h7FFF_FFFF);
      ph = ($urandom_range(0, 4) == 0) ? pl - 1 : pl + $urandom_range(0, 1000);
      dh = ($urandom_range(0, 4) == 0) ? dl - 1 : dl + $urandom_range(0, 1000);
      run_cmd(rop, ridx, ren, pl, ph, dl, dh, $urandom_range(0, 2), 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
